// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the ID-stage register file and its scoreboard.
//   DATA_W_DEF / ADDR_W_DEF : default register width and address width
//   reg_data_t / reg_addr_t : register data and address types at default widths
//   ZERO_ADDR               : index of the optional hardwired zero register
// -----------------------------------------------------------------------------
package pipe_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 4;

   typedef logic [DATA_W_DEF-1:0] reg_data_t;
   typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

   localparam reg_addr_t ZERO_ADDR = '0;

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
// Per-register busy bits tracking in-flight producers.
//   clk, reset           : clock, synchronous active-high reset
//   issue_en, issue_addr : producer leaving ID sets busy[issue_addr]
//   wr_en, wr_addr       : writeback clears busy[wr_addr]
//   rs_addr, rt_addr     : lookup addresses
//   rs_busy, rt_busy     : registered busy bits at the lookup addresses
//   busy_vec             : whole scoreboard
// -----------------------------------------------------------------------------
module reg_scoreboard
   import pipe_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int ZERO_REG = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 issue_en,
   input  logic [ADDR_W-1:0]    issue_addr,
   input  logic                 wr_en,
   input  logic [ADDR_W-1:0]    wr_addr,
   input  logic [ADDR_W-1:0]    rs_addr,
   input  logic [ADDR_W-1:0]    rt_addr,
   output logic                 rs_busy,
   output logic                 rt_busy,
   output logic [2**ADDR_W-1:0] busy_vec
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] busy_d;

   // Set has priority over clear: a new producer issuing to the register that
   // is retiring this cycle supersedes the retiring one.
   always_comb begin
      busy_d = busy_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (issue_en && (issue_addr == ADDR_W'(i))) begin
            busy_d[i] = 1'b1;
         end else if (wr_en && (wr_addr == ADDR_W'(i))) begin
            busy_d[i] = 1'b0;
         end
      end
      if (ZERO_REG != 0) begin
         busy_d[ZERO_ADDR] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   // Busy is reported from state only; a same-cycle writeback does not hide it.
   assign rs_busy  = busy_q[rs_addr];
   assign rt_busy  = busy_q[rt_addr];
   assign busy_vec = busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// -----------------------------------------------------------------------------
// reg_file_sb
// ID-stage register file: two combinational read ports, one synchronous write
// port, optional same-cycle write bypass, optional hardwired zero register and
// an integrated busy scoreboard.
//   clk, reset                 : clock, synchronous active-high reset
//   rs_addr/rs_data            : read port A (combinational)
//   rt_addr/rt_data            : read port B (combinational)
//   wr_en, wr_addr, wr_data    : writeback port
//   issue_en, issue_addr       : destination of the instruction leaving ID
//   rs_busy, rt_busy, busy_vec : scoreboard outputs
// -----------------------------------------------------------------------------
module reg_file_sb
   import pipe_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int ZERO_REG = 0,
   parameter int BYPASS   = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [ADDR_W-1:0]    rs_addr,
   input  logic [ADDR_W-1:0]    rt_addr,
   output logic [DATA_W-1:0]    rs_data,
   output logic [DATA_W-1:0]    rt_data,
   input  logic                 wr_en,
   input  logic [ADDR_W-1:0]    wr_addr,
   input  logic [DATA_W-1:0]    wr_data,
   input  logic                 issue_en,
   input  logic [ADDR_W-1:0]    issue_addr,
   output logic                 rs_busy,
   output logic                 rt_busy,
   output logic [2**ADDR_W-1:0] busy_vec
);

   localparam int DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_ADDR);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              wr_keep;

   // A write to the zero register is dropped entirely, so it must not bypass.
   assign wr_keep = wr_en && !((ZERO_REG != 0) && (wr_addr == ZADDR));

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_keep) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // Priority: zero register, then bypass, then stored value.
   always_comb begin
      rs_data = mem_q[rs_addr];
      if ((BYPASS != 0) && wr_keep && (wr_addr == rs_addr)) begin
         rs_data = wr_data;
      end
      if ((ZERO_REG != 0) && (rs_addr == ZADDR)) begin
         rs_data = '0;
      end
   end

   always_comb begin
      rt_data = mem_q[rt_addr];
      if ((BYPASS != 0) && wr_keep && (wr_addr == rt_addr)) begin
         rt_data = wr_data;
      end
      if ((ZERO_REG != 0) && (rt_addr == ZADDR)) begin
         rt_data = '0;
      end
   end

   reg_scoreboard #(
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk        (clk),
      .reset      (reset),
      .issue_en   (issue_en),
      .issue_addr (issue_addr),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .rs_addr    (rs_addr),
      .rt_addr    (rt_addr),
      .rs_busy    (rs_busy),
      .rt_busy    (rt_busy),
      .busy_vec   (busy_vec)
   );

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised clocked register file for the ID stage of the pipeline.
- Provides two combinational read ports (rs, rt) and one synchronous write port (writeback).
- Reads bypass a same-cycle write; an optional hardwired zero register is supported.
- An integrated per-register busy scoreboard tracks in-flight producers so the hazard unit can stall dependent instructions.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 4, address width; depth = 2**ADDR_W entries.
- ZERO_REG, 0, when 1, entry 0 always reads 0, ignores writes, and is never busy.
- BYPASS, 1, when 1, a read of the address being written this cycle returns wr_data.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rs_addr  in  ADDR_W  read port A address.
- rt_addr  in  ADDR_W  read port B address.
- rs_data  out  DATA_W  read port A data (combinational).
- rt_data  out  DATA_W  read port B data (combinational).
- wr_en  in  1  writeback strobe.
- wr_addr  in  ADDR_W  writeback address.
- wr_data  in  DATA_W  writeback data.
- issue_en  in  1  an instruction with a destination leaves ID this cycle.
- issue_addr  in  ADDR_W  destination register of the issuing instruction.
- rs_busy  out  1  busy[rs_addr] (combinational).
- rt_busy  out  1  busy[rt_addr] (combinational).
- busy_vec  out  2**ADDR_W  full scoreboard, for debug and the hazard unit.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous, active-high and sampled on the rising edge of clk.
- Reset:
  - All entries become 0 and all busy bits become 0.
  - Consequently rs_data = rt_data = 0, rs_busy = rt_busy = 0 and busy_vec = 0 in the cycle after reset.
  - reset overrides wr_en and issue_en in the same cycle.
- Storage: mem[0 .. 2**ADDR_W-1] of DATA_W bits.
- Write: on the rising edge with wr_en = 1, mem[wr_addr] <= wr_data. Write latency is 1 cycle.
- Read: zero latency and purely combinational from addresses and current state.
  - rs_data = mem[rs_addr]; rt_data = mem[rt_addr].
  - Both ports are independent; rs_addr == rt_addr is legal.
- Bypass (BYPASS = 1): if wr_en = 1 and wr_addr == rs_addr, rs_data = wr_data in the same cycle; same rule for rt. With BYPASS = 0, the old value is returned until the next cycle.
- Zero register (ZERO_REG = 1):
  - Reads of address 0 return 0, including when bypass would otherwise apply.
  - Writes to address 0 are dropped.
  - issue_addr = 0 does not set busy[0].
- Scoreboard, evaluated per entry at each rising edge:
  - issue_en = 1 and issue_addr == i: busy[i] <= 1.
  - Otherwise, wr_en = 1 and wr_addr == i: busy[i] <= 0.
  - Otherwise busy[i] holds.
  - Set wins over clear when both target the same address, because the new producer supersedes the retiring one.
  - A writeback to a non-busy register is legal, writes data and leaves busy at 0.
- Busy reporting: rs_busy and rt_busy reflect registered busy bits only; they are not bypassed. A register whose writeback is happening this cycle still reports busy = 1 this cycle. The hazard unit relies on BYPASS for data, not on busy.
- Overflow: no producer counting; a second issue to an already-busy register keeps busy = 1. The first writeback clears the bit, so the pipeline must guarantee in-order writeback per register.
- Unknown addresses: none; every ADDR_W value is a valid entry.

Decomposition:
- Shared package pipe_pkg holds:
  - DATA_W_DEF = 32 and ADDR_W_DEF = 4;
  - typedefs reg_addr_t and reg_data_t;
  - constant ZERO_ADDR = 0.
- One natural sub-module, reg_scoreboard (busy vector: set/clear/reset logic plus two read muxes), instantiated inside reg_file_sb.
- Data array and bypass muxes stay in the top module.

Test Plan:
- Reset then read: assert reset 1 cycle, then rs_addr = 3, rt_addr = 15 -> rs_data = 0, rt_data = 0, busy_vec = 0.
- Write then read: wr_en = 1, wr_addr = 7, wr_data = 0x0000_000F; next cycle rs_addr = 7 -> rs_data = 0x0000_000F. With BYPASS = 1, the same-cycle read of 7 already shows 0x0000_000F; with BYPASS = 0 it shows 0 that cycle.
- Zero register: ZERO_REG = 1; write 0xDEAD_BEEF to 0 with issue_en on addr 0 -> rs_data(0) = 0 in that cycle and after, busy[0] stays 0. ZERO_REG = 0 -> reads 0xDEAD_BEEF next cycle.
- Scoreboard lifecycle: issue 5 at cycle 1 -> rs_busy (rs_addr = 5) = 1 from cycle 2; wr_en to 5 at cycle 4 -> busy = 1 during cycle 4, 0 from cycle 5.
- Simultaneous set and clear: same cycle issue_addr = 9 and wr_addr = 9 (busy[9] = 1 beforehand) -> busy[9] = 1 next cycle, mem[9] updated to wr_data.
- Reset mid-operation: busy[2] = busy[9] = 1 and mem[2] = 0x55; assert reset together with wr_en to 2 -> next cycle mem[2] = 0, busy_vec = 0.
